// File: rtl/bgpu_eu_dispatcher.sv
// Instruction dispatcher: routes decoded instructions into per-EU FIFOs,
// drops illegal encodings and keeps a saturating count of them.
module bgpu_eu_dispatcher #(
  parameter int unsigned NumEu        = 4,
  parameter int unsigned EuIdxWidth   = (NumEu > 2) ? $clog2(NumEu) : 1,
  parameter int unsigned SubtypeWidth = 6,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned FifoDepth    = 2,
  parameter logic [NumEu*SubtypeWidth-1:0] EuMaxSubtype = {6'h06, 6'h03, 6'h05, 6'h0E}
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             inst_valid_i,
  output logic                             inst_ready_o,
  input  logic [EuIdxWidth-1:0]            inst_eu_i,
  input  logic [SubtypeWidth-1:0]          inst_subtype_i,
  input  logic [PayloadWidth-1:0]          inst_payload_i,
  output logic [NumEu-1:0]                 eu_valid_o,
  input  logic [NumEu-1:0]                 eu_ready_i,
  output logic [NumEu*SubtypeWidth-1:0]    eu_subtype_o,
  output logic [NumEu*PayloadWidth-1:0]    eu_payload_o,
  output logic                             illegal_o,
  output logic [15:0]                      illegal_count_o,
  output logic [NumEu-1:0]                 eu_empty_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  logic [SubtypeWidth-1:0] sub_mem [NumEu][FifoDepth];
  logic [PayloadWidth-1:0] pay_mem [NumEu][FifoDepth];
  logic [PtrW-1:0]         rd_ptr_q [NumEu];
  logic [PtrW-1:0]         wr_ptr_q [NumEu];
  logic [CntW-1:0]         cnt_q    [NumEu];

  logic        illegal_q;
  logic [15:0] illegal_count_q;

  logic             sel_legal;
  logic             sel_full;
  logic             accept;
  logic [NumEu-1:0] push;
  logic [NumEu-1:0] pop;

  // Wrap at FifoDepth rather than 2**PtrW so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // An index with no matching EU leaves sel_legal low, covering eu >= NumEu.
  always_comb begin
    sel_legal = 1'b0;
    sel_full  = 1'b0;
    for (int unsigned k = 0; k < NumEu; k++) begin
      if (inst_eu_i == EuIdxWidth'(k)) begin
        sel_legal = (inst_subtype_i <= EuMaxSubtype[k*SubtypeWidth +: SubtypeWidth]);
        sel_full  = (cnt_q[k] == CntW'(FifoDepth));
      end
    end
  end

  assign inst_ready_o = !flush_i && (!sel_legal || !sel_full);
  assign accept       = inst_valid_i && inst_ready_o;

  always_comb begin
    push         = '0;
    pop          = '0;
    eu_valid_o   = '0;
    eu_empty_o   = '0;
    eu_subtype_o = '0;
    eu_payload_o = '0;
    for (int unsigned k = 0; k < NumEu; k++) begin
      push[k]       = accept && sel_legal && (inst_eu_i == EuIdxWidth'(k));
      eu_valid_o[k] = (cnt_q[k] != '0);
      eu_empty_o[k] = (cnt_q[k] == '0);
      pop[k]        = eu_valid_o[k] && eu_ready_i[k];
      eu_subtype_o[k*SubtypeWidth +: SubtypeWidth] = sub_mem[k][rd_ptr_q[k]];
      eu_payload_o[k*PayloadWidth +: PayloadWidth] = pay_mem[k][rd_ptr_q[k]];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NumEu; k++) begin
      if (push[k]) begin
        sub_mem[k][wr_ptr_q[k]] <= inst_subtype_i;
        pay_mem[k][wr_ptr_q[k]] <= inst_payload_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NumEu; k++) begin
      if (rst_i || flush_i) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end else begin
        if (push[k]) wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
        if (pop[k])  rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
        if (push[k] && !pop[k])      cnt_q[k] <= cnt_q[k] + 1'b1;
        else if (pop[k] && !push[k]) cnt_q[k] <= cnt_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      illegal_q <= accept && !sel_legal;
      if (accept && !sel_legal && (illegal_count_q != '1))
        illegal_count_q <= illegal_count_q + 1'b1;
    end
  end

  assign illegal_o       = illegal_q;
  assign illegal_count_o = illegal_count_q;

  a_inst_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (inst_valid_i && !inst_ready_o) |=>
      ($stable(inst_eu_i) && $stable(inst_subtype_i) && $stable(inst_payload_i)));

endmodule

// File: tb/tb_bgpu_eu_dispatcher.sv
// Bench for bgpu_eu_dispatcher: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_bgpu_eu_dispatcher;

  localparam int NE = 4;
  localparam int SW = 6;
  localparam int PW = 64;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          inst_valid = 1'b0;
  logic          inst_ready;
  logic [1:0]    inst_eu = '0;
  logic [SW-1:0] inst_sub = '0;
  logic [PW-1:0] inst_pay = '0;
  logic [NE-1:0] eu_valid;
  logic [NE-1:0] eu_ready = '1;
  logic [NE*SW-1:0] eu_sub;
  logic [NE*PW-1:0] eu_pay;
  logic          illegal;
  logic [15:0]   ill_cnt;
  logic [NE-1:0] eu_empty;

  logic          valid3 = 1'b0;
  logic          ready3;
  logic [1:0]    eu3 = '0;
  logic [SW-1:0] sub3 = '0;
  logic [PW-1:0] pay3 = '0;
  logic [2:0]    eu_valid3;
  logic [2:0]    eu_ready3 = '1;
  logic [3*SW-1:0] eu_sub3;
  logic [3*PW-1:0] eu_pay3;
  logic          illegal3;
  logic [15:0]   ill_cnt3;
  logic [2:0]    eu_empty3;

  always #5 clk = ~clk;

  bgpu_eu_dispatcher #(.NumEu(4), .SubtypeWidth(6), .PayloadWidth(64), .FifoDepth(2)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
    .inst_eu_i(inst_eu), .inst_subtype_i(inst_sub), .inst_payload_i(inst_pay),
    .eu_valid_o(eu_valid), .eu_ready_i(eu_ready),
    .eu_subtype_o(eu_sub), .eu_payload_o(eu_pay),
    .illegal_o(illegal), .illegal_count_o(ill_cnt), .eu_empty_o(eu_empty)
  );

  bgpu_eu_dispatcher #(.NumEu(3), .FifoDepth(2), .EuMaxSubtype({6'h03, 6'h05, 6'h0E})) d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .inst_valid_i(valid3), .inst_ready_o(ready3),
    .inst_eu_i(eu3), .inst_subtype_i(sub3), .inst_payload_i(pay3),
    .eu_valid_o(eu_valid3), .eu_ready_i(eu_ready3),
    .eu_subtype_o(eu_sub3), .eu_payload_o(eu_pay3),
    .illegal_o(illegal3), .illegal_count_o(ill_cnt3), .eu_empty_o(eu_empty3)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one queue per EU of {subtype, payload}.
  logic [SW+PW-1:0] q [NE][$];
  int max_tbl [NE] = '{14, 5, 3, 6};
  int unsigned mcnt = 0;
  bit mill = 0;
  bit armed = 0;

  always @(negedge clk) begin
    bit legal;
    bit rdy;
    if (armed) begin
      legal = (int'(inst_sub) <= max_tbl[inst_eu]);
      rdy   = !flush && (!legal || q[inst_eu].size() < FD);
      chk("inst_ready", inst_ready, rdy);
      for (int k = 0; k < NE; k++) begin
        chk($sformatf("eu_valid[%0d]", k), eu_valid[k], q[k].size() != 0);
        chk($sformatf("eu_empty[%0d]", k), eu_empty[k], q[k].size() == 0);
        if (q[k].size() != 0) begin
          chk($sformatf("head_sub[%0d]", k), eu_sub[k*SW +: SW], q[k][0][SW+PW-1:PW]);
          chk($sformatf("head_pay[%0d]", k), eu_pay[k*PW +: PW], q[k][0][PW-1:0]);
        end
      end
      chk("illegal_o", illegal, mill);
      chk("illegal_count", ill_cnt, mcnt);
      for (int k = 0; k < NE; k++) begin
        if (flush) q[k].delete();
        else if (q[k].size() != 0 && eu_ready[k]) void'(q[k].pop_front());
      end
      mill = 0;
      if (inst_valid && rdy) begin
        if (legal) q[inst_eu].push_back({inst_sub, inst_pay});
        else begin
          mill = 1;
          if (mcnt < 32'hFFFF) mcnt++;
        end
      end
    end
    if (rst) begin
      for (int k = 0; k < NE; k++) q[k].delete();
      mcnt  = 0;
      mill  = 0;
      armed = 1;
    end
  end

  task automatic send(input logic [1:0] eu, input logic [SW-1:0] sub,
                      input logic [PW-1:0] pay, output int waits);
    bit done;
    done = 0;
    waits = 0;
    inst_valid = 1'b1;
    inst_eu = eu;
    inst_sub = sub;
    inst_pay = pay;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (inst_ready) done = 1;
      else waits++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: eu %0d never accepted, required accept within 50 cycles", eu);
    end
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic drive_phase();
    @(posedge clk); #1;
  endtask

  int w;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_empty", eu_empty, 4'hF);
    chk("reset_valid", eu_valid, 4'h0);
    chk("reset_count", ill_cnt, 16'h0);
    drive_phase();

    // IU single instruction
    send(2'd0, 6'h05, 64'hA5, w);
    @(negedge clk);
    chk("iu_valid", eu_valid, 4'b0001);
    chk("iu_sub", eu_sub[5:0], 6'h05);
    chk("iu_pay", eu_pay[63:0], 64'hA5);
    @(negedge clk);
    chk("iu_empty_after_pop", eu_empty[0], 1'b1);
    drive_phase();

    // LSU backpressure with BRU bypassing it
    eu_ready = 4'b1101;
    send(2'd1, 6'h01, 64'h11, w);
    send(2'd1, 6'h02, 64'h12, w);
    send(2'd2, 6'h03, 64'h23, w);
    chk("bru_no_wait", w, 0);
    inst_valid = 1'b1; inst_eu = 2'd1; inst_sub = 6'h04; inst_pay = 64'h14;
    repeat (3) begin
      @(negedge clk);
      chk("lsu_full_ready", inst_ready, 1'b0);
    end
    drive_phase();
    eu_ready = 4'hF;
    send(2'd1, 6'h04, 64'h14, w);
    chk("lsu_third_wait", w, 1);
    repeat (3) drive_phase();

    // Illegal BRU subtype
    send(2'd2, 6'h07, 64'h77, w);
    chk("bru_illegal_wait", w, 0);
    @(negedge clk);
    chk("illegal_pulse", illegal, 1'b1);
    chk("illegal_count_1", ill_cnt, 16'h1);
    chk("bru_not_queued", eu_valid[2], 1'b0);
    @(negedge clk);
    chk("illegal_pulse_end", illegal, 1'b0);
    drive_phase();

    // NumEu = 3: index 3 is out of range
    valid3 = 1'b1; eu3 = 2'd3; sub3 = 6'h00; pay3 = 64'h33;
    @(negedge clk);
    chk("d3_ready_oob", ready3, 1'b1);
    drive_phase();
    valid3 = 1'b0;
    @(negedge clk);
    chk("d3_illegal", illegal3, 1'b1);
    chk("d3_count", ill_cnt3, 16'h1);
    chk("d3_nothing_queued", eu_valid3, 3'b000);
    drive_phase();
    eu_ready3 = 3'b000;
    valid3 = 1'b1; eu3 = 2'd2; sub3 = 6'h03; pay3 = 64'hBEEF;
    drive_phase();
    valid3 = 1'b0;
    @(negedge clk);
    chk("d3_legal_valid", eu_valid3, 3'b100);
    chk("d3_legal_pay", eu_pay3[191:128], 64'hBEEF);
    chk("d3_no_illegal", illegal3, 1'b0);
    drive_phase();
    eu_ready3 = '1;

    // FPU back-to-back push/pop at count 1 across pointer wrap
    for (int i = 0; i < 10; i++) begin
      send(2'd3, 6'(i % 7), 64'h100 + 64'(i), w);
      chk("fpu_no_wait", w, 0);
    end
    @(negedge clk);
    chk("fpu_last_head", eu_pay[255:192], 64'h109);
    chk("fpu_last_sub", eu_sub[23:18], 6'h02);
    @(negedge clk);
    chk("fpu_drained", eu_empty[3], 1'b1);
    drive_phase();

    // Fill all FIFOs, then flush with an instruction pending
    eu_ready = 4'h0;
    for (int e = 0; e < NE; e++) begin
      send(2'(e), 6'h00, 64'(e * 16), w);
      send(2'(e), 6'h01, 64'(e * 16 + 1), w);
    end
    chk("all_full", eu_valid, 4'hF);
    inst_valid = 1'b1; inst_eu = 2'd0; inst_sub = 6'h01; inst_pay = 64'hF0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", inst_ready, 1'b0);
    drive_phase();
    flush = 1'b0;
    inst_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", eu_valid, 4'h0);
    chk("flush_count_kept", ill_cnt, 16'h1);
    drive_phase();
    eu_ready = 4'hF;

    // Saturation of the illegal counter
    inst_valid = 1'b1; inst_eu = 2'd0; inst_sub = 6'h3F; inst_pay = '0;
    repeat (65533) @(posedge clk);
    @(negedge clk);
    chk("count_fffe", ill_cnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    chk("count_saturated", ill_cnt, 16'hFFFF);
    chk("sat_pulse", illegal, 1'b1);
    drive_phase();

    // Reset mid-operation
    eu_ready = 4'h0;
    send(2'd1, 6'h00, 64'h55, w);
    rst = 1'b1;
    drive_phase();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", eu_valid, 4'h0);
    chk("midrst_empty", eu_empty, 4'hF);
    chk("midrst_count", ill_cnt, 16'h0);
    chk("midrst_illegal", illegal, 1'b0);
    drive_phase();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bgpu_eu_dispatcher.md
Name: bgpu_eu_dispatcher

Overview:
- Routes decoded warp instructions (execution-unit index, subtype, opaque payload) from the issue stage to NumEu execution units over valid/ready handshakes.
- Each EU has a private FIFO, so a stalled EU does not block dispatch to the others.
- Detects illegal encodings (EU index out of range, or subtype above that EU's maximum), drops them, and reports them.
- Sits between the warp scheduler/decoder and the IU/LSU/BRU/FPU instances.

Parameters:
- NumEu, 4, number of execution units (2..8).
- EuIdxWidth, $clog2(NumEu) (minimum 1), width of the EU index field.
- SubtypeWidth, 6, width of the instruction subtype field.
- PayloadWidth, 64, opaque per-instruction payload (warp id, registers, mask); not interpreted.
- FifoDepth, 2, entries per EU FIFO (1..8).
- EuMaxSubtype, {6'h06, 6'h03, 6'h05, 6'h0E}, packed NumEu×SubtypeWidth; slice k is the highest legal subtype for EU k (defaults: IU 0x0E, LSU 0x05, BRU 0x03, FPU 0x06).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all queued instructions
- inst_valid_i  in  1  instruction offered
- inst_ready_o  out  1  instruction accepted this cycle when valid
- inst_eu_i  in  EuIdxWidth  target EU index
- inst_subtype_i  in  SubtypeWidth  EU-specific opcode
- inst_payload_i  in  PayloadWidth  opaque payload
- eu_valid_o  out  NumEu  per-EU head valid
- eu_ready_i  in  NumEu  per-EU consumer ready
- eu_subtype_o  out  NumEu*SubtypeWidth  per-EU head subtype
- eu_payload_o  out  NumEu*PayloadWidth  per-EU head payload
- illegal_o  out  1  one-cycle pulse: illegal instruction dropped
- illegal_count_o  out  16  saturating count of dropped instructions
- eu_empty_o  out  NumEu  per-EU FIFO empty

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - All FIFO counts and pointers are 0.
  - eu_valid_o = 0; eu_empty_o = all ones.
  - illegal_o = 0; illegal_count_o = 0.
  - eu_subtype_o and eu_payload_o are don't-care while the matching eu_valid_o is 0.
- Legality:
  - An instruction is illegal if inst_eu_i >= NumEu, or inst_subtype_i > EuMaxSubtype[inst_eu_i].
  - The comparison is unsigned.
- Accept condition (inst_ready_o, combinational from inst_eu_i and FIFO state):
  - Illegal instruction: ready = !flush_i.
  - Legal instruction: ready = !flush_i && count[inst_eu_i] < FifoDepth.
  - Ready does not depend on same-cycle eu_ready_i; there is no full-FIFO bypass.
- Handshake rules:
  - Upstream holds valid, eu, subtype and payload stable until accepted.
  - Downstream pops EU k when eu_valid_o[k] && eu_ready_i[k].
  - eu_valid_o[k] never drops without a pop, except on flush or reset.
- Legal accept: push into FIFO[inst_eu_i]. Data is visible on eu_valid_o the next cycle (latency 1), in order per EU.
- Illegal accept:
  - Nothing is pushed.
  - illegal_o = 1 on the next cycle only.
  - illegal_count_o increments, saturating at 16'hFFFF.
- Simultaneous push and pop on the same FIFO (count < FifoDepth): count is unchanged and ordering is preserved. With count == 1, the new entry becomes head after the old head leaves.
- Pointers wrap modulo FifoDepth; any depth is supported, not only powers of two.
- flush_i:
  - All FIFO counts and pointers clear at the clock edge; eu_valid_o = 0 next cycle.
  - Pops in the flush cycle are irrelevant.
  - illegal_count_o is retained; no accept occurs in the flush cycle.
- Reset asserted mid-operation: identical to reset values next cycle; queued instructions are lost.
- FIFOs are independent: a full FIFO[k] stalls only instructions targeting k.
- Assertion: inst_eu_i, inst_subtype_i and inst_payload_i stable while inst_valid_i && !inst_ready_o.

Test Plan:
- Reset, then send IU subtype 0x05 payload 0xA5 → one cycle later eu_valid_o = 4'b0001, head subtype 0x05 payload 0xA5; pop → eu_empty_o[0] = 1.
- Hold eu_ready_i[1] = 0 and send 3 LSU instructions (FifoDepth 2) → first two accepted; third sees inst_ready_o = 0 until one pop. Meanwhile a BRU instruction is accepted immediately.
- Send BRU subtype 0x07 → inst_ready_o = 1, nothing queued, illegal_o pulses one cycle, illegal_count_o = 1.
- With NumEu = 3, send inst_eu_i = 3 → dropped as illegal.
- Preset count to 0xFFFE and inject 3 illegal instructions → illegal_count_o saturates at 0xFFFF.
- Back-to-back push/pop on FPU at count 1 for 10 cycles → count stays 1, FIFO order preserved across pointer wrap.
- Fill all four FIFOs, assert flush_i with inst_valid_i high → inst_ready_o = 0 that cycle; next cycle eu_valid_o = 0 and illegal_count_o unchanged.
